// File: rtl/exec_ls_if.sv
// exec_ls_if: issue-queue handshake, data-memory port and CDB signals of the
// load/store execution unit, bundled so the unit and its environment share one
// definition. The unit takes the slave view; the environment takes the master view.

interface exec_ls_if #(
    parameter int DMEM_AW = 10
);
    // Issue queue -> unit
    logic               issuels_opcode;
    logic [5:0]         issuels_rttag;
    logic [31:0]        issuels_addr;
    logic [31:0]        issuels_data;
    logic               issuels_ready;
    logic               issuels_done;

    // Unit <-> data memory
    logic [DMEM_AW-1:0] dmem_addr;
    logic [31:0]        dmem_wdata;
    logic               dmem_re;
    logic               dmem_we;
    logic [31:0]        dmem_rdata;
    logic               dmem_ack;

    // Unit <-> common data bus arbiter
    logic               cdb_req;
    logic               cdb_grant;
    logic [5:0]         cdb_tag_out;
    logic [31:0]        cdb_data_out;

    modport slave (
        input  issuels_opcode,
        input  issuels_rttag,
        input  issuels_addr,
        input  issuels_data,
        input  issuels_ready,
        output issuels_done,
        output dmem_addr,
        output dmem_wdata,
        output dmem_re,
        output dmem_we,
        input  dmem_rdata,
        input  dmem_ack,
        output cdb_req,
        input  cdb_grant,
        output cdb_tag_out,
        output cdb_data_out
    );

    modport master (
        output issuels_opcode,
        output issuels_rttag,
        output issuels_addr,
        output issuels_data,
        output issuels_ready,
        input  issuels_done,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_re,
        input  dmem_we,
        output dmem_rdata,
        output dmem_ack,
        input  cdb_req,
        output cdb_grant,
        input  cdb_tag_out,
        input  cdb_data_out
    );
endinterface

// File: rtl/exec_ls.sv
// exec_ls: load/store execution unit. Accepts one memory operation at a time
// from the load/store issue queue, performs it against a variable-latency data
// port, and publishes load results on the CDB through a request/grant arbiter.
// Stores retire silently on memory acknowledge.

`ifndef ISSUELS_FUNC_SW
`define ISSUELS_FUNC_SW 1'b1
`endif

module exec_ls #(
    parameter int DMEM_AW = 10,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    exec_ls_if.slave         bus,
    output logic             misalign,
    output logic [CNT_W-1:0] n_loads,
    output logic [CNT_W-1:0] n_stores
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        CDB  = 2'd2
    } state_t;

    state_t             state_q,    state_d;

    // Captured operation
    logic               is_store_q, is_store_d;
    logic [5:0]         tag_q,      tag_d;
    logic [DMEM_AW-1:0] addr_q,     addr_d;
    logic [31:0]        wdata_q,    wdata_d;

    // Load result awaiting broadcast
    logic [31:0]        result_q,   result_d;

    // Registered strobes
    logic               re_q,       re_d;
    logic               we_q,       we_d;
    logic               req_q,      req_d;

    // Status
    logic               misalign_q, misalign_d;
    logic [CNT_W-1:0]   n_loads_q,  n_loads_d;
    logic [CNT_W-1:0]   n_stores_q, n_stores_d;

    // Qualified events
    logic               accept;
    logic               mem_ack;
    logic               grant_take;

    // Byte-address bits above the data-memory word range are not used.
    logic               unused_addr_hi;
    assign unused_addr_hi = ^bus.issuels_addr[31:DMEM_AW+2];

    // Qualify handshake inputs by state; ack or grant outside their state is dropped.
    always_comb begin
        accept     = (state_q == IDLE) && bus.issuels_ready && !reset;
        mem_ack    = (state_q == MEM)  && bus.dmem_ack;
        grant_take = (state_q == CDB)  && bus.cdb_grant;
    end

    // Next-state, operand capture, counters and strobe values for the coming cycle.
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        tag_d      = tag_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        result_d   = result_q;
        misalign_d = misalign_q;
        n_loads_d  = n_loads_q;
        n_stores_d = n_stores_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    is_store_d = (bus.issuels_opcode == `ISSUELS_FUNC_SW);
                    tag_d      = bus.issuels_rttag;
                    addr_d     = bus.issuels_addr[DMEM_AW+1:2];
                    wdata_d    = bus.issuels_data;
                    if (bus.issuels_addr[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                    end
                    state_d = MEM;
                end
            end
            MEM: begin
                if (mem_ack) begin
                    if (is_store_q) begin
                        n_stores_d = n_stores_q + CNT_W'(1);
                        state_d    = IDLE;
                    end else begin
                        result_d = bus.dmem_rdata;
                        state_d  = CDB;
                    end
                end
            end
            CDB: begin
                if (grant_take) begin
                    n_loads_d = n_loads_q + CNT_W'(1);
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes are decoded from the next state so they come straight off flops.
        re_d  = (state_d == MEM) && !is_store_d;
        we_d  = (state_d == MEM) &&  is_store_d;
        req_d = (state_d == CDB);
    end

    // State, operation registers, strobes and counters; reset aborts any op in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            is_store_q <= 1'b0;
            tag_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            result_q   <= '0;
            re_q       <= 1'b0;
            we_q       <= 1'b0;
            req_q      <= 1'b0;
            misalign_q <= 1'b0;
            n_loads_q  <= '0;
            n_stores_q <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            tag_q      <= tag_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            result_q   <= result_d;
            re_q       <= re_d;
            we_q       <= we_d;
            req_q      <= req_d;
            misalign_q <= misalign_d;
            n_loads_q  <= n_loads_d;
            n_stores_q <= n_stores_d;
        end
    end

    // Done is the only combinational output: the queue pops on the edge ending an IDLE+ready cycle.
    assign bus.issuels_done = accept;

    assign bus.dmem_addr    = addr_q;
    assign bus.dmem_wdata   = wdata_q;
    assign bus.dmem_re      = re_q;
    assign bus.dmem_we      = we_q;
    assign bus.cdb_req      = req_q;
    assign bus.cdb_tag_out  = tag_q;
    assign bus.cdb_data_out = result_q;

    assign misalign = misalign_q;
    assign n_loads  = n_loads_q;
    assign n_stores = n_stores_q;

    // The data port never sees both strobes, and a CDB request never overlaps a memory request.
    a_strobe_excl : assert property (@(posedge clk) disable iff (reset) !(re_q && we_q));
    a_req_excl    : assert property (@(posedge clk) disable iff (reset) !(req_q && (re_q || we_q)));

endmodule

// File: tb/tb_exec_ls.sv
// tb_exec_ls: directed bench for the load/store execution unit. A transaction
// model tracks the op held by the unit and is compared against the DUT every
// cycle; each directed scenario also checks hand-computed results.

`ifndef ISSUELS_FUNC_SW
`define ISSUELS_FUNC_SW 1'b1
`endif

module tb_exec_ls;

    localparam int DMEM_AW = 10;
    localparam int CNT_W   = 16;

    logic             clk;
    logic             reset;
    logic             misalign;
    logic [CNT_W-1:0] n_loads;
    logic [CNT_W-1:0] n_stores;

    exec_ls_if #(.DMEM_AW(DMEM_AW)) bus ();

    exec_ls #(.DMEM_AW(DMEM_AW), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .misalign (misalign),
        .n_loads  (n_loads),
        .n_stores (n_stores)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction model: which op the unit holds and what it is waiting for.
    // ------------------------------------------------------------------
    bit          m_busy;        // an accepted op has not retired yet
    bit          m_store;
    bit [5:0]    m_tag;
    bit [31:0]   m_byte_addr;
    bit [31:0]   m_wdata;
    bit          m_has_result;  // load data returned, waiting for the bus
    bit [31:0]   m_result;
    bit          m_mis;
    int unsigned m_nloads;
    int unsigned m_nstores;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy       = 1'b0;
            m_has_result = 1'b0;
            m_mis        = 1'b0;
            m_nloads     = 0;
            m_nstores    = 0;
        end else if (!m_busy) begin
            if (bus.issuels_ready) begin
                m_busy      = 1'b1;
                m_store     = (bus.issuels_opcode == `ISSUELS_FUNC_SW);
                m_tag       = bus.issuels_rttag;
                m_byte_addr = bus.issuels_addr;
                m_wdata     = bus.issuels_data;
                if (bus.issuels_addr % 4 != 0) m_mis = 1'b1;
            end
        end else if (!m_has_result) begin
            if (bus.dmem_ack) begin
                if (m_store) begin
                    m_nstores = m_nstores + 1;
                    m_busy    = 1'b0;
                end else begin
                    m_result     = bus.dmem_rdata;
                    m_has_result = 1'b1;
                end
            end
        end else if (bus.cdb_grant) begin
            m_nloads     = m_nloads + 1;
            m_has_result = 1'b0;
            m_busy       = 1'b0;
        end
    end

    // Per-cycle comparison of the DUT against the model, away from the clock edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            bit in_mem;
            in_mem = m_busy && !m_has_result;
            check("done",     32'(bus.issuels_done), 32'(!reset && bus.issuels_ready && !m_busy));
            check("dmem_re",  32'(bus.dmem_re),      32'(in_mem && !m_store));
            check("dmem_we",  32'(bus.dmem_we),      32'(in_mem && m_store));
            check("cdb_req",  32'(bus.cdb_req),      32'(m_has_result));
            check("misalign", 32'(misalign),         32'(m_mis));
            check("n_loads",  32'(n_loads),          m_nloads % (1 << CNT_W));
            check("n_stores", 32'(n_stores),         m_nstores % (1 << CNT_W));
            if (in_mem) begin
                check("dmem_addr", 32'(bus.dmem_addr), (m_byte_addr / 4) % (1 << DMEM_AW));
                if (m_store) check("dmem_wdata", bus.dmem_wdata, m_wdata);
            end
            if (m_has_result) begin
                check("cdb_tag",  32'(bus.cdb_tag_out), 32'(m_tag));
                check("cdb_data", bus.cdb_data_out,     m_result);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an op for one cycle; returns one cycle later with the op accepted and ready dropped.
    task automatic issue(input bit store, input bit [5:0] tag, input bit [31:0] addr, input bit [31:0] data);
        bus.issuels_opcode = store ? `ISSUELS_FUNC_SW : ~`ISSUELS_FUNC_SW;
        bus.issuels_rttag  = tag;
        bus.issuels_addr   = addr;
        bus.issuels_data   = data;
        bus.issuels_ready  = 1'b1;
        step();
        bus.issuels_ready  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_a;
        int cnt_b;
        int cnt_c;
        int pops;

        reset              = 1'b1;
        bus.issuels_opcode = 1'b0;
        bus.issuels_rttag  = '0;
        bus.issuels_addr   = '0;
        bus.issuels_data   = '0;
        bus.issuels_ready  = 1'b1;
        bus.dmem_rdata     = '0;
        bus.dmem_ack       = 1'b0;
        bus.cdb_grant      = 1'b0;

        // Reset values, with ready held high
        @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        check("rst_done",     32'(bus.issuels_done), 32'h0);
        check("rst_re",       32'(bus.dmem_re),      32'h0);
        check("rst_we",       32'(bus.dmem_we),      32'h0);
        check("rst_req",      32'(bus.cdb_req),      32'h0);
        check("rst_n_loads",  32'(n_loads),          32'h0);
        check("rst_n_stores", 32'(n_stores),         32'h0);
        check("rst_misalign", 32'(misalign),         32'h0);
        check("rst_dmem_addr",32'(bus.dmem_addr),    32'h0);
        check("rst_cdb_tag",  32'(bus.cdb_tag_out),  32'h0);
        check("rst_cdb_data", bus.cdb_data_out,      32'h0);
        step();
        bus.issuels_ready = 1'b0;
        step();
        reset = 1'b0;
        step();

        // Store 0x10 / 0xDEADBEEF, ack in the third MEM cycle
        issue(1'b1, 6'h00, 32'h10, 32'hDEADBEEF);
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 6; i++) begin
            bus.dmem_ack = (i == 2);
            @(negedge clk);
            if (bus.dmem_we && bus.dmem_addr == 10'd4 && bus.dmem_wdata == 32'hDEADBEEF) cnt_a++;
            if (bus.cdb_req) cnt_b++;
            step();
        end
        bus.dmem_ack = 1'b0;
        check("store_we_cycles", 32'(cnt_a),    32'd3);
        check("store_no_req",    32'(cnt_b),    32'd0);
        check("store_count",     32'(n_stores), 32'd1);

        // Load tag 0x2A from 0x20, 1-cycle ack, grant withheld 4 cycles
        issue(1'b0, 6'h2A, 32'h20, 32'h0);
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 8; i++) begin
            bus.dmem_ack   = (i == 0);
            bus.dmem_rdata = (i == 0) ? 32'h12345678 : 32'h0;
            bus.cdb_grant  = (i == 5);
            @(negedge clk);
            if (bus.cdb_req && bus.cdb_tag_out == 6'h2A && bus.cdb_data_out == 32'h12345678) cnt_a++;
            if (bus.issuels_done) cnt_b++;
            step();
        end
        bus.dmem_ack  = 1'b0;
        bus.cdb_grant = 1'b0;
        check("load_req_cycles", 32'(cnt_a),   32'd5);
        check("load_no_done",    32'(cnt_b),   32'd0);
        check("load_count",      32'(n_loads), 32'd1);

        // Back-pressure: ready held high over a queued load then store; ack and grant held high
        pops               = 0;
        bus.dmem_ack       = 1'b1;
        bus.cdb_grant      = 1'b1;
        bus.dmem_rdata     = 32'hCAFEF00D;
        bus.issuels_opcode = ~`ISSUELS_FUNC_SW;
        bus.issuels_rttag  = 6'h07;
        bus.issuels_addr   = 32'h44;
        bus.issuels_data   = 32'h0;
        bus.issuels_ready  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.issuels_done) pops++;
            step();
            if (pops == 1) begin
                bus.issuels_opcode = `ISSUELS_FUNC_SW;
                bus.issuels_rttag  = 6'h00;
                bus.issuels_addr   = 32'h48;
                bus.issuels_data   = 32'hA5A5_0F0F;
            end
            bus.issuels_ready = (pops < 2);
        end
        bus.dmem_ack  = 1'b0;
        bus.cdb_grant = 1'b0;
        check("bp_done_pulses", 32'(pops),     32'd2);
        check("bp_n_loads",     32'(n_loads),  32'd2);
        check("bp_n_stores",    32'(n_stores), 32'd2);

        // Misaligned load at 0x13
        check("mis_before", 32'(misalign), 32'd0);
        issue(1'b0, 6'h05, 32'h13, 32'h0);
        cnt_a = 0;
        for (int i = 0; i < 6; i++) begin
            bus.dmem_ack   = (i == 1);
            bus.dmem_rdata = 32'h0000_1313;
            bus.cdb_grant  = (i == 2);
            @(negedge clk);
            if (bus.dmem_re && bus.dmem_addr == 10'd4) cnt_a++;
            step();
        end
        bus.dmem_ack  = 1'b0;
        bus.cdb_grant = 1'b0;
        check("mis_re_addr4", 32'(cnt_a),   32'd2);
        check("mis_loads",    32'(n_loads), 32'd3);
        step();
        step();
        @(negedge clk);
        check("mis_sticky", 32'(misalign), 32'd1);
        step();

        // Reset while a result waits for a grant
        issue(1'b0, 6'h11, 32'h40, 32'h0);
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'h0BAD_F00D;
        step();
        bus.dmem_ack = 1'b0;
        step();
        step();
        @(negedge clk);
        check("pre_rst_req", 32'(bus.cdb_req), 32'd1);
        step();
        bus.cdb_grant = 1'b1;
        reset         = 1'b1;
        @(negedge clk);
        check("midrst_req",      32'(bus.cdb_req), 32'd0);
        check("midrst_n_loads",  32'(n_loads),     32'd0);
        check("midrst_misalign", 32'(misalign),    32'd0);
        step();
        reset = 1'b0;
        step();
        @(negedge clk);
        check("postrst_n_loads", 32'(n_loads),     32'd0);
        check("postrst_req",     32'(bus.cdb_req), 32'd0);
        step();
        bus.cdb_grant = 1'b0;
        issue(1'b1, 6'h00, 32'h8, 32'h55);
        bus.dmem_ack = 1'b1;
        @(negedge clk);
        check("postrst_we",    32'(bus.dmem_we),   32'd1);
        check("postrst_addr",  32'(bus.dmem_addr), 32'd2);
        check("postrst_wdata", bus.dmem_wdata,     32'h55);
        step();
        bus.dmem_ack = 1'b0;
        @(negedge clk);
        check("postrst_stores", 32'(n_stores),   32'd1);
        check("postrst_idle",   32'(bus.dmem_we), 32'd0);
        step();
        step();

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_ls.md
# exec_ls

Load/store execution unit. It is the consumer end of the `issuels_*` handshake driven by the load/store issue queue. It accepts one memory operation at a time and performs it against a variable-latency data-memory port. Load results are published on the common data bus through a request/grant arbiter; stores retire silently once memory acknowledges.

## Interface
Parameters:
- `DMEM_AW`, default 10: data-memory word-address width. Uses `issuels_addr[DMEM_AW+1:2]`.
- `CNT_W`, default 16: width of the retired-operation counters.

Ports:
- `clk`  in  1: clock. All flops update on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `issuels_opcode`  in  1: equal to `` `ISSUELS_FUNC_SW`` means store; any other value means load.
- `issuels_rttag`  in  6: destination tag for a load. Ignored for a store.
- `issuels_addr`  in  32: effective byte address, already offset-added.
- `issuels_data`  in  32: store data.
- `issuels_ready`  in  1: queue head is valid and its operands are resolved.
- `issuels_done`  out  1: acceptance strobe. The queue pops its head on the edge ending this cycle.
- `dmem_addr`  out  `DMEM_AW`: word address.
- `dmem_wdata`  out  32: store data.
- `dmem_re`  out  1: read request, level.
- `dmem_we`  out  1: write request, level.
- `dmem_rdata`  in  32: read data, valid in a cycle where `dmem_ack` is high.
- `dmem_ack`  in  1: completes the current request. Any latency of ≥1 cycle.
- `cdb_req`  out  1: load result pending broadcast.
- `cdb_grant`  in  1: arbiter grant. The bus samples the result in this cycle.
- `cdb_tag_out`  out  6: tag of the pending result.
- `cdb_data_out`  out  32: data of the pending result.
- `misalign`  out  1: sticky flag, set when an accepted op had `issuels_addr[1:0] != 0`.
- `n_loads`  out  `CNT_W`: loads retired. Increments on the cycle the grant is taken.
- `n_stores`  out  `CNT_W`: stores retired. Increments on the cycle the ack is taken.

## Operation
- FSM states: IDLE, MEM, CDB.
- **IDLE:**
  - `issuels_done = issuels_ready`. This term is combinational and is the only cycle in which done can be high.
  - On acceptance, capture opcode, tag, `addr[DMEM_AW+1:2]` and data into op registers, then go to MEM.
  - If `addr[1:0] != 0`, set `misalign`. The access still proceeds with the low bits dropped.
- **MEM:**
  - Drive `dmem_addr`/`dmem_wdata` from the op registers.
  - Assert `dmem_re` for a load, `dmem_we` for a store. Exactly one is high, and both are held until ack.
  - Ack on a store: increment `n_stores`, go to IDLE.
  - Ack on a load: capture `dmem_rdata` into the result register, go to CDB.
- **CDB:**
  - `cdb_req = 1`. `cdb_tag_out` and `cdb_data_out` come from registers and are stable until grant.
  - On `cdb_grant`: increment `n_loads`, go to IDLE.
  - A grant seen in any state other than CDB is ignored.
- `issuels_done` is 0 in MEM and CDB. The queue holds its head until the unit returns to IDLE.
- `dmem_re` and `dmem_we` are 0 in IDLE and CDB. `dmem_ack` is ignored outside MEM.
- Counters wrap modulo 2^`CNT_W`.
- `misalign` clears only on reset.

## Timing
- Reset: state IDLE. `issuels_done=0` (`issuels_ready` is gated by state), `dmem_re=dmem_we=0`, `cdb_req=0`. `cdb_tag_out`, `cdb_data_out`, `dmem_addr`, `dmem_wdata`, counters and `misalign` are all 0.
- Accept in cycle T puts the unit in MEM at T+1, with `dmem_re`/`dmem_we` high from T+1.
- Ack at cycle T+k (k≥1):
  - store: back in IDLE at T+k+1, and a new op can be accepted at T+k+1;
  - load: in CDB at T+k+1.
- Grant at cycle G puts the unit in IDLE at G+1. Minimum load occupancy is 3 cycles (accept, 1-cycle ack, immediate grant).
- Back-to-back stores with 1-cycle ack: one store accepted every 2 cycles.
- Reset asserted mid-operation aborts immediately. A pending CDB result is discarded, and no counter increments for the aborted op.
- `cdb_req` may stay high for any number of cycles. It drops in the cycle after grant.

## Test plan
- **Reset values:** assert reset with `issuels_ready=1` → `issuels_done=0`, `dmem_re=dmem_we=0`, `cdb_req=0`, counters 0.
- **Store:**
  - Stimulus: store addr `0x10`, data `0xDEADBEEF`, ack after 3 cycles.
  - Required: `dmem_we` high 3 cycles at `dmem_addr=4`, `wdata=0xDEADBEEF`; `n_stores=1`; `cdb_req` never high.
- **Load:**
  - Stimulus: load tag `0x2A`, addr `0x20`, `rdata=0x12345678` with 1-cycle ack, grant withheld 4 cycles.
  - Required: `cdb_req` high 5 cycles with tag `0x2A`/data `0x12345678` stable; `issuels_done` low throughout; `n_loads=1` after grant.
- **Back-pressure:** hold `issuels_ready=1` continuously with a queued load then store → `issuels_done` pulses exactly once per op, only in IDLE, two pulses total.
- **Misalign:** load at addr `0x13` → `dmem_addr=4`, `misalign=1` and stays 1 after the op retires.
- **Reset mid-flight:** reset during CDB with grant pending → `cdb_req=0` immediately, `n_loads` stays 0, next op accepted normally after reset.
